key_sw_led_ctrl: RTL and testbench
==================================

Name: key_sw_led_ctrl

Overview:
Parametrised successor to the lab's key/switch-to-LED demo block. Raw board keys and switches are synchronised, and each key is debounced and edge-detected. The LED bank is driven in one of four modes, and key[0] presses step through the modes. The block sits between board I/O pins and the LED bank and is the standard front-panel block for later lab projects.

Parameters:
- KEY_W, 4, number of keys; must be >= 4 because key[0..3] have fixed functions.
- SW_W, 4, number of slide switches; must be >= 1.
- LED_W, 8, number of LEDs; must be >= 2.
- DB_CYCLES, 20, consecutive stable cycles needed before a debounced key changes state; must be >= 2.
- RUN_DIV, 1000, clock cycles per running-light step; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- key  input  KEY_W  raw key inputs, asynchronous to clk, active-high (see Optional Feature).
- sw  input  SW_W  raw switch inputs, asynchronous to clk.
- led  output  LED_W  registered LED drive.
- key_press  output  KEY_W  one-cycle pulse per debounced key press.
- mode  output  2  current mode: 0 DIRECT, 1 COUNT, 2 RUN, 3 HOLD.

Behaviour:
- Reset: on any clk edge with rst_n=0, all of the following clear to 0: led, mode, key_press, debounced keys, debounce counters, sync flops, counter, RUN prescaler, HOLD register.
  - Reset asserted mid-operation aborts everything the same way; no state survives.
- Synchronisers: two flops each for key and sw; ksync/ssync lag the pins by 2 cycles.
- Debounce, per key, independent:
  - Counter increments while ksync[i] != kdb[i] and clears whenever they are equal.
  - kdb[i] takes ksync[i] on the edge where the counter would reach DB_CYCLES; the counter then clears.
  - Any glitch shorter than DB_CYCLES cycles produces no change.
- key_press[i]: high for exactly one cycle, in the cycle after kdb[i] rises 0->1. Releases produce no pulse.
- Mode FSM:
  - A key_press[0] advances the mode 0->1->2->3->0 (wrap). The new mode is visible on the next edge.
  - Other key presses in the same cycle as key_press[0] are ignored.
- led output: registered; all updates take effect one cycle after their cause.
- DIRECT (0):
  - led = zero-extend/truncate of {kdb, ssync} to LED_W. sw occupies the low bits, keys the bits above.
  - Defaults: led = {kdb[3:0], ssync[3:0]}.
  - Latency: sw pin to led = 3 cycles.
- COUNT (1):
  - led shows an LED_W-bit counter.
  - key_press[1] increments it, wrapping all-ones -> 0. key_press[2] decrements it, wrapping 0 -> all-ones.
  - key_press[1] and key_press[2] in the same cycle: no change.
  - key_press[3] clears it to 0 and has priority over [1]/[2].
  - The counter value is retained while in other modes.
- RUN (2):
  - On entry, led = one-hot bit 0 and the prescaler clears.
  - Every RUN_DIV cycles led rotates by one position: left (toward the MSB) when ssync[0]=0, right when ssync[0]=1.
  - Wrap: MSB -> bit 0 going left, bit 0 -> MSB going right.
  - The direction is sampled at each step.
- HOLD (3):
  - On entry, led is frozen at its previous value.
  - key_press[1] inverts all led bits; key_press[3] clears led to 0.
- Unused key_press bits (index >= 4) still pulse but have no effect inside the block.

Optional Feature:
- Macro: KEY_ACTIVE_LOW_EN.
- Defined: each raw key bit is inverted before the first sync flop, so a pressed board key (pin=0) reads as 1 internally. The sync flops and debounced state still reset to 0 (released), so no spurious press follows reset.
- Undefined: keys are active-high and pass straight to the synchroniser.
- All other behaviour is identical in both builds.

Test Plan (bench uses DB_CYCLES=4, RUN_DIV=8, defaults otherwise):
1. Reset, then sw=4'b0101 and key=0, held 10 cycles -> mode=0, led=8'b0000_0101. Then key=4'b1010, held 10 cycles -> key_press[1] and key_press[3] pulse once each (key[0] stays low, so no mode change); led=8'b1010_0101.
2. key[1] glitch high for 3 cycles -> no key_press pulse, led unchanged. key[1] held high for 6 cycles -> exactly one key_press[1] pulse, 1 cycle wide, 4 cycles after ksync rises.
3. Press key[0] once -> mode=1. Press key[2] once -> led=8'hFF (wrap). Press key[1] twice -> led=8'h01. Press key[1] and key[2] simultaneously -> led stays 8'h01. Press key[3] -> led=8'h00.
4. Press key[0] into RUN with sw[0]=0 -> led=8'h01, then 8'h02 after 8 cycles, reaching 8'h80 and wrapping to 8'h01. Set sw[0]=1 -> led steps 8'h01 -> 8'h80.
5. Press key[0] into HOLD with led=8'h04 -> led stays 8'h04. Press key[1] -> led=8'hFB. Press key[0] -> mode=0 (wrap). Return to COUNT -> the prior counter value is shown.
6. Assert rst_n=0 for 1 cycle mid-RUN -> led=0, mode=0, key_press=0 on that edge. Rerun scenario 1 with KEY_ACTIVE_LOW_EN defined and inverted key stimulus -> identical led values.

Source files
------------

// File: rtl/key_sw_led_ctrl.sv
// key_sw_led_ctrl: synced/debounced keys and switches drive an LED bank in four modes; KEY_ACTIVE_LOW_EN inverts raw keys
module key_sw_led_ctrl #(
    parameter int KEY_W     = 4,
    parameter int SW_W      = 4,
    parameter int LED_W     = 8,
    parameter int DB_CYCLES = 20,
    parameter int RUN_DIV   = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic [KEY_W-1:0] key_press,
    output logic [1:0]       mode
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam int PW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
    localparam logic [CW-1:0] DMAX = CW'(DB_CYCLES - 1);
    localparam logic [PW-1:0] PMAX = PW'(RUN_DIV - 1);
    typedef enum logic [1:0] {DIRECT, COUNT, RUN, HOLD} mode_t;
    mode_t st, st_n;
    logic [KEY_W-1:0] kin, k1, ksync, kdb, hit;
    logic [SW_W-1:0] s1, ssync;
    logic [CW-1:0] dbc [KEY_W];
    logic [LED_W-1:0] ctr, ctr_n, led_n, direct;
    logic [PW-1:0] pre, pre_n;
`ifdef KEY_ACTIVE_LOW_EN
    assign kin = ~key;
`else
    assign kin = key;
`endif
    assign mode = st;
    assign direct = LED_W'({kdb, ssync});
    for (genvar g = 0; g < KEY_W; g++) begin : g_hit
        assign hit[g] = (ksync[g] != kdb[g]) && (dbc[g] == DMAX);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k1 <= '0;
            ksync <= '0;
            s1 <= '0;
            ssync <= '0;
            kdb <= '0;
            key_press <= '0;
            for (int i = 0; i < KEY_W; i++) dbc[i] <= '0;
            st <= DIRECT;
            ctr <= '0;
            pre <= '0;
            led <= '0;
        end else begin
            k1 <= kin;
            ksync <= k1;
            s1 <= sw;
            ssync <= s1;
            kdb <= kdb ^ hit;
            key_press <= hit & ksync;
            for (int i = 0; i < KEY_W; i++) dbc[i] <= (ksync[i] == kdb[i] || hit[i]) ? '0 : dbc[i] + 1'b1;
            st <= st_n;
            ctr <= ctr_n;
            pre <= pre_n;
            led <= led_n;
        end
    end
    always_comb begin
        st_n = key_press[0] ? mode_t'(st + 2'd1) : st;
        ctr_n = ctr;
        pre_n = pre;
        led_n = led;
        if (key_press[0]) begin
            led_n = st_n == DIRECT ? direct : st_n == COUNT ? ctr : st_n == RUN ? LED_W'(1) : led;
            pre_n = '0;
        end else begin
            case (st)
                DIRECT: led_n = direct;
                COUNT: begin
                    ctr_n = key_press[3] ? '0 :
                            (key_press[1] && !key_press[2]) ? ctr + 1'b1 :
                            (key_press[2] && !key_press[1]) ? ctr - 1'b1 : ctr;
                    led_n = ctr_n;
                end
                RUN: begin
                    pre_n = pre == PMAX ? '0 : pre + 1'b1;
                    led_n = pre != PMAX ? led :
                            ssync[0] ? {led[0], led[LED_W-1:1]} : {led[LED_W-2:0], led[LED_W-1]};
                end
                HOLD: led_n = key_press[3] ? '0 : key_press[1] ? ~led : led;
            endcase
        end
    end
endmodule

// File: tb/tb_key_sw_led_ctrl.sv
// tb_key_sw_led_ctrl: scoreboarded key_press pulses plus per-scenario LED/mode checks
module tb_key_sw_led_ctrl;
    logic clk = 1'b0, rst_n;
    logic [3:0] key, sw, key_press;
    logic [7:0] led;
    logic [1:0] mode;
    typedef struct {logic [3:0] m; int c;} ev_t;
    ev_t kp_exp[$], kp_obs[$];
    int cyc = 0, compared = 0, mismatched = 0;

    key_sw_led_ctrl #(.KEY_W(4), .SW_W(4), .LED_W(8), .DB_CYCLES(4), .RUN_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .sw(sw),
        .led(led), .key_press(key_press), .mode(mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        if (rst_n === 1'b1 && key_press !== 4'b0) kp_obs.push_back('{key_press, cyc});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [3:0] kv(input logic [3:0] v);
`ifdef KEY_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_key(input logic [3:0] m);
        kp_exp.push_back('{m, cyc + 6});
        key = kv(m);
    endtask

    task automatic press(input logic [3:0] m);
        drive_key(m);
        tick(8);
        key = kv(4'b0);
        tick(8);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        key = kv(4'b0);
        sw = 4'b0;
        tick(3);
        compared += 3;
        if (led !== 8'h00) begin mismatched++; $display("FAIL reset_led: got %h expected 00", led); end
        if (mode !== 2'd0) begin mismatched++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        if (key_press !== 4'b0) begin mismatched++; $display("FAIL reset_kp: got %b expected 0000", key_press); end
        rst_n = 1'b1;
    endtask

    task automatic test_direct;
        sw = 4'b0101;
        key = kv(4'b0);
        tick(10);
        compared += 2;
        if (mode !== 2'd0) begin mismatched++; $display("FAIL direct_mode: got %0d expected 0", mode); end
        if (led !== 8'h05) begin mismatched++; $display("FAIL direct_sw: got %h expected 05", led); end
        drive_key(4'b1010);
        tick(10);
        compared += 2;
        if (led !== 8'hA5) begin mismatched++; $display("FAIL direct_keys: got %h expected a5", led); end
        if (mode !== 2'd0) begin mismatched++; $display("FAIL direct_nomode: got %0d expected 0", mode); end
        key = kv(4'b0);
        tick(10);
        compared++;
        if (led !== 8'h05) begin mismatched++; $display("FAIL direct_release: got %h expected 05", led); end
    endtask

    task automatic test_debounce;
        key = kv(4'b0010);
        tick(3);
        key = kv(4'b0);
        tick(10);
        compared += 2;
        if (kp_obs.size() !== kp_exp.size()) begin mismatched++; $display("FAIL glitch_pulse: got %0d pulses expected %0d", kp_obs.size(), kp_exp.size()); end
        if (led !== 8'h05) begin mismatched++; $display("FAIL glitch_led: got %h expected 05", led); end
        drive_key(4'b0010);
        tick(6);
        key = kv(4'b0);
        tick(10);
        compared++;
        if (led !== 8'h05) begin mismatched++; $display("FAIL hold6_led: got %h expected 05", led); end
    endtask

    task automatic test_count;
        press(4'b0001);
        compared += 2;
        if (mode !== 2'd1) begin mismatched++; $display("FAIL count_mode: got %0d expected 1", mode); end
        if (led !== 8'h00) begin mismatched++; $display("FAIL count_init: got %h expected 00", led); end
        press(4'b0100);
        compared++;
        if (led !== 8'hFF) begin mismatched++; $display("FAIL count_dec_wrap: got %h expected ff", led); end
        press(4'b0010);
        compared++;
        if (led !== 8'h00) begin mismatched++; $display("FAIL count_inc_wrap: got %h expected 00", led); end
        press(4'b0010);
        compared++;
        if (led !== 8'h01) begin mismatched++; $display("FAIL count_inc: got %h expected 01", led); end
        press(4'b0110);
        compared++;
        if (led !== 8'h01) begin mismatched++; $display("FAIL count_both: got %h expected 01", led); end
        press(4'b1000);
        compared++;
        if (led !== 8'h00) begin mismatched++; $display("FAIL count_clear: got %h expected 00", led); end
        press(4'b0100);
        compared++;
        if (led !== 8'hFF) begin mismatched++; $display("FAIL count_dec2: got %h expected ff", led); end
    endtask

    task automatic test_run;
        logic [7:0] exp;
        sw = 4'b0100;
        drive_key(4'b0001);
        for (int i = 0; i < 20 && mode !== 2'd2; i++) tick(1);
        compared += 2;
        if (mode !== 2'd2) begin mismatched++; $display("FAIL run_enter: got %0d expected 2", mode); end
        if (led !== 8'h01) begin mismatched++; $display("FAIL run_onehot: got %h expected 01", led); end
        key = kv(4'b0);
        exp = 8'h01;
        for (int k = 0; k < 8; k++) begin
            tick(8);
            exp = {exp[6:0], exp[7]};
            compared++;
            if (led !== exp) begin mismatched++; $display("FAIL run_left%0d: got %h expected %h", k, led, exp); end
        end
        sw = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            tick(8);
            exp = {exp[0], exp[7:1]};
            compared++;
            if (led !== exp) begin mismatched++; $display("FAIL run_right%0d: got %h expected %h", k, led, exp); end
        end
    endtask

    task automatic test_hold;
        drive_key(4'b0001);
        for (int i = 0; i < 20 && mode !== 2'd3; i++) tick(1);
        compared += 2;
        if (mode !== 2'd3) begin mismatched++; $display("FAIL hold_enter: got %0d expected 3", mode); end
        if (led !== 8'h04) begin mismatched++; $display("FAIL hold_freeze: got %h expected 04", led); end
        key = kv(4'b0);
        tick(10);
        compared++;
        if (led !== 8'h04) begin mismatched++; $display("FAIL hold_stay: got %h expected 04", led); end
        press(4'b0010);
        compared++;
        if (led !== 8'hFB) begin mismatched++; $display("FAIL hold_invert: got %h expected fb", led); end
        press(4'b0001);
        compared += 2;
        if (mode !== 2'd0) begin mismatched++; $display("FAIL mode_wrap: got %0d expected 0", mode); end
        if (led !== 8'h05) begin mismatched++; $display("FAIL wrap_direct: got %h expected 05", led); end
        press(4'b0001);
        compared += 2;
        if (mode !== 2'd1) begin mismatched++; $display("FAIL recount_mode: got %0d expected 1", mode); end
        if (led !== 8'hFF) begin mismatched++; $display("FAIL count_retained: got %h expected ff", led); end
    endtask

    task automatic test_mid_reset;
        press(4'b0001);
        compared++;
        if (mode !== 2'd2) begin mismatched++; $display("FAIL rerun_mode: got %0d expected 2", mode); end
        tick(3);
        rst_n = 1'b0;
        tick(1);
        compared += 3;
        if (led !== 8'h00) begin mismatched++; $display("FAIL midrst_led: got %h expected 00", led); end
        if (mode !== 2'd0) begin mismatched++; $display("FAIL midrst_mode: got %0d expected 0", mode); end
        if (key_press !== 4'b0) begin mismatched++; $display("FAIL midrst_kp: got %b expected 0000", key_press); end
        rst_n = 1'b1;
        test_direct();
    endtask

    task automatic test_scoreboard;
        int n;
        compared++;
        if (kp_obs.size() !== kp_exp.size()) begin mismatched++; $display("FAIL kp_count: got %0d pulses expected %0d", kp_obs.size(), kp_exp.size()); end
        n = kp_obs.size() < kp_exp.size() ? kp_obs.size() : kp_exp.size();
        for (int i = 0; i < n; i++) begin
            ev_t o, e;
            o = kp_obs.pop_front();
            e = kp_exp.pop_front();
            compared++;
            if (o.m !== e.m || o.c !== e.c) begin
                mismatched++;
                $display("FAIL kp_pulse%0d: got %b@%0d expected %b@%0d", i, o.m, o.c, e.m, e.c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_debounce();
        test_count();
        test_run();
        test_hold();
        test_mid_reset();
        test_scoreboard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
